// File: rtl/aq_axi_lite_local_bridge.sv
// aq_axi_lite_local_bridge
//   Bridges an AXI4-Lite slave port onto a simple single-cycle-select local bus
//   master. Only one access is in flight at a time. Addresses pass through
//   unmodified, and there is no address decode.
//
//   Parameters
//     TIMEOUT_CYCLES : number of CLK cycles LOCAL_CS may stay high without
//                      LOCAL_ACK before the access is aborted with SLVERR.
//
//   Ports
//     CLK, RST_N            : clock (rising edge) and synchronous active-low reset
//     S_AXI_AW* / S_AXI_W*  : write address / write data channels
//     S_AXI_B*              : write response channel
//     S_AXI_AR* / S_AXI_R*  : read address / read data channels
//     LOCAL_CS, LOCAL_RNW   : local access strobe and direction (1 = read)
//     LOCAL_ADDR/BE/WDATA   : local access address, byte enables and write data
//     LOCAL_ACK, LOCAL_RDATA: slave completion strobe and read data
//
//   All outputs are registered.
module aq_axi_lite_local_bridge #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        CLK,
   input  logic        RST_N,
   // write address
   input  logic [31:0] S_AXI_AWADDR,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   // write data
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   // write response
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   // read address
   input  logic [31:0] S_AXI_ARADDR,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   // read data
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   // local bus master
   output logic        LOCAL_CS,
   output logic        LOCAL_RNW,
   input  logic        LOCAL_ACK,
   output logic [31:0] LOCAL_ADDR,
   output logic [3:0]  LOCAL_BE,
   output logic [31:0] LOCAL_WDATA,
   input  logic [31:0] LOCAL_RDATA
);

   localparam int             TW     = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]     OKAY   = 2'b00;
   localparam logic [1:0]     SLVERR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ,
      S_RRESP
   } state_t;

   // write request assembled from independently arriving AW and W beats
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_req_t;

   state_t        state, state_n;
   logic          aw_lat, aw_lat_n;
   logic          w_lat, w_lat_n;
   wr_req_t       wreq, wreq_n;
   logic          prio_rd, prio_rd_n;   // 1: a read wins the next tie
   logic [TW-1:0] tcnt, tcnt_n;

   logic          awready_n, wready_n, arready_n;
   logic          bvalid_n, rvalid_n;
   logic [1:0]    bresp_n, rresp_n;
   logic [31:0]   rdata_n;
   logic          cs_n, rnw_n;
   logic [31:0]   addr_n, wdata_n;
   logic [3:0]    be_n;

   logic          aw_hs, w_hs, ar_hs;
   logic          wr_req, rd_req, offer_rd;

   assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   always_comb begin
      state_n   = state;
      aw_lat_n  = aw_lat;
      w_lat_n   = w_lat;
      wreq_n    = wreq;
      prio_rd_n = prio_rd;
      tcnt_n    = tcnt;
      bvalid_n  = S_AXI_BVALID;
      bresp_n   = S_AXI_BRESP;
      rvalid_n  = S_AXI_RVALID;
      rresp_n   = S_AXI_RRESP;
      rdata_n   = S_AXI_RDATA;
      cs_n      = LOCAL_CS;
      rnw_n     = LOCAL_RNW;
      addr_n    = LOCAL_ADDR;
      wdata_n   = LOCAL_WDATA;
      be_n      = LOCAL_BE;
      awready_n = 1'b0;
      wready_n  = 1'b0;
      arready_n = 1'b0;
      wr_req    = 1'b0;
      rd_req    = 1'b0;
      offer_rd  = 1'b0;

      case (state)
         S_IDLE: begin
            if (aw_hs) begin
               aw_lat_n    = 1'b1;
               wreq_n.addr = S_AXI_AWADDR;
            end
            if (w_hs) begin
               w_lat_n     = 1'b1;
               wreq_n.data = S_AXI_WDATA;
               wreq_n.strb = S_AXI_WSTRB;
            end
            // The READY offers are mutually exclusive, so ar_hs never
            // coincides with aw_hs/w_hs.
            if (ar_hs) begin
               state_n = S_READ;
               cs_n    = 1'b1;
               rnw_n   = 1'b1;
               addr_n  = S_AXI_ARADDR;
               be_n    = 4'hF;
               wdata_n = 32'h0;
               tcnt_n  = '0;
            end else if (aw_lat_n && w_lat_n) begin
               state_n  = S_WRITE;
               cs_n     = 1'b1;
               rnw_n    = 1'b0;
               addr_n   = wreq_n.addr;
               wdata_n  = wreq_n.data;
               be_n     = wreq_n.strb;
               tcnt_n   = '0;
               aw_lat_n = 1'b0;
               w_lat_n  = 1'b0;
            end
         end

         S_WRITE: begin
            // ACK takes precedence over a timeout firing in the same cycle
            if (LOCAL_ACK || tcnt == T_LAST) begin
               state_n   = S_WRESP;
               cs_n      = 1'b0;
               rnw_n     = 1'b0;
               addr_n    = 32'h0;
               wdata_n   = 32'h0;
               be_n      = 4'h0;
               bvalid_n  = 1'b1;
               bresp_n   = LOCAL_ACK ? OKAY : SLVERR;
               prio_rd_n = 1'b1;
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end

         S_WRESP: begin
            if (S_AXI_BREADY) begin
               state_n  = S_IDLE;
               bvalid_n = 1'b0;
               bresp_n  = OKAY;
            end
         end

         S_READ: begin
            if (LOCAL_ACK || tcnt == T_LAST) begin
               state_n   = S_RRESP;
               cs_n      = 1'b0;
               rnw_n     = 1'b0;
               addr_n    = 32'h0;
               wdata_n   = 32'h0;
               be_n      = 4'h0;
               rvalid_n  = 1'b1;
               rresp_n   = LOCAL_ACK ? OKAY : SLVERR;
               rdata_n   = LOCAL_ACK ? LOCAL_RDATA : 32'h0;
               prio_rd_n = 1'b0;
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end

         S_RRESP: begin
            if (S_AXI_RREADY) begin
               state_n  = S_IDLE;
               rvalid_n = 1'b0;
               rresp_n  = OKAY;
               rdata_n  = 32'h0;
            end
         end

         default: state_n = S_IDLE;
      endcase

      // READY is registered, so the channel to offer next cycle is chosen now.
      // Once a write half is latched, only the missing half is offered.
      // Otherwise only one side is offered: the priority side, unless only
      // the other side currently has a request waiting.
      if (state_n == S_IDLE) begin
         if (aw_lat_n || w_lat_n) begin
            awready_n = !aw_lat_n;
            wready_n  = !w_lat_n;
         end else begin
            wr_req    = S_AXI_AWVALID | S_AXI_WVALID;
            rd_req    = S_AXI_ARVALID;
            offer_rd  = prio_rd_n ? !(wr_req && !rd_req) : (rd_req && !wr_req);
            awready_n = !offer_rd;
            wready_n  = !offer_rd;
            arready_n = offer_rd;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state         <= S_IDLE;
         aw_lat        <= 1'b0;
         w_lat         <= 1'b0;
         wreq          <= '0;
         prio_rd       <= 1'b0;
         tcnt          <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RRESP   <= 2'b00;
         S_AXI_RDATA   <= 32'h0;
         LOCAL_CS      <= 1'b0;
         LOCAL_RNW     <= 1'b0;
         LOCAL_ADDR    <= 32'h0;
         LOCAL_WDATA   <= 32'h0;
         LOCAL_BE      <= 4'h0;
      end else begin
         state         <= state_n;
         aw_lat        <= aw_lat_n;
         w_lat         <= w_lat_n;
         wreq          <= wreq_n;
         prio_rd       <= prio_rd_n;
         tcnt          <= tcnt_n;
         S_AXI_AWREADY <= awready_n;
         S_AXI_WREADY  <= wready_n;
         S_AXI_ARREADY <= arready_n;
         S_AXI_BVALID  <= bvalid_n;
         S_AXI_BRESP   <= bresp_n;
         S_AXI_RVALID  <= rvalid_n;
         S_AXI_RRESP   <= rresp_n;
         S_AXI_RDATA   <= rdata_n;
         LOCAL_CS      <= cs_n;
         LOCAL_RNW     <= rnw_n;
         LOCAL_ADDR    <= addr_n;
         LOCAL_WDATA   <= wdata_n;
         LOCAL_BE      <= be_n;
      end
   end

endmodule

// File: tb/tb_aq_axi_lite_local_bridge.sv
// Directed self-checking bench for aq_axi_lite_local_bridge.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_aq_axi_lite_local_bridge;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] S_AXI_AWADDR;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [31:0] S_AXI_ARADDR;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        LOCAL_CS;
   logic        LOCAL_RNW;
   logic        LOCAL_ACK;
   logic [31:0] LOCAL_ADDR;
   logic [3:0]  LOCAL_BE;
   logic [31:0] LOCAL_WDATA;
   logic [31:0] LOCAL_RDATA;

   int n_checks = 0;
   int n_fail   = 0;

   aq_axi_lite_local_bridge #(.TIMEOUT_CYCLES(256)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .LOCAL_CS(LOCAL_CS), .LOCAL_RNW(LOCAL_RNW), .LOCAL_ACK(LOCAL_ACK),
      .LOCAL_ADDR(LOCAL_ADDR), .LOCAL_BE(LOCAL_BE), .LOCAL_WDATA(LOCAL_WDATA),
      .LOCAL_RDATA(LOCAL_RDATA)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      RST_N = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
      S_AXI_RREADY = 0; LOCAL_ACK = 0; LOCAL_RDATA = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID,
           S_AXI_RRESP, S_AXI_RDATA, LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_BE, LOCAL_WDATA} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got cs=%b addr=%h rdata=%h rdy=%b%b%b, all required 0",
                  LOCAL_CS, LOCAL_ADDR, S_AXI_RDATA, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
      end
      RST_N = 1'b1;
      @(negedge CLK);
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_ready: got aw/w/ar=%b%b%b expected 110",
                  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
      end
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   // write 0x100 to 0x8, slave acks two cycles after CS rises
   task automatic test_write();
      S_AXI_AWADDR = 32'h8; S_AXI_AWVALID = 1;
      S_AXI_WDATA = 32'h100; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      @(negedge CLK);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      for (int c = 1; c <= 2; c++) begin
         n_checks++;
         if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_WDATA, LOCAL_BE, S_AXI_BVALID} !==
             {1'b1, 1'b0, 32'h8, 32'h100, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_local_c%0d: got cs=%b rnw=%b addr=%h wd=%h be=%h bv=%b required 1 0 8 100 f 0",
                     c, LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_WDATA, LOCAL_BE, S_AXI_BVALID);
         end
         if (c == 2) LOCAL_ACK = 1;
         @(negedge CLK);
      end
      LOCAL_ACK = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_ADDR, LOCAL_WDATA, S_AXI_BVALID, S_AXI_BRESP} !== {1'b0, 32'h0, 32'h0, 1'b1, 2'b00}) begin
         n_fail++;
         $display("FAIL wr_resp: got cs=%b addr=%h wd=%h bv=%b bresp=%b required 0 0 0 1 00",
                  LOCAL_CS, LOCAL_ADDR, LOCAL_WDATA, S_AXI_BVALID, S_AXI_BRESP);
      end
      S_AXI_BREADY = 1;
      @(negedge CLK);
      S_AXI_BREADY = 0;
      n_checks++;
      if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_ARREADY} !== 3'b001) begin
         n_fail++;
         $display("FAIL wr_done: got bv/awr/arr=%b%b%b required 001", S_AXI_BVALID, S_AXI_AWREADY, S_AXI_ARREADY);
      end
   endtask

   // read 0x1000, slave returns 0x2A on the first CS cycle
   task automatic test_read();
      S_AXI_ARADDR = 32'h1000; S_AXI_ARVALID = 1;
      @(negedge CLK);
      S_AXI_ARVALID = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_BE, S_AXI_ARREADY} !== {1'b1, 1'b1, 32'h1000, 4'hF, 1'b0}) begin
         n_fail++;
         $display("FAIL rd_local: got cs=%b rnw=%b addr=%h be=%h arr=%b required 1 1 1000 f 0",
                  LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_BE, S_AXI_ARREADY);
      end
      LOCAL_ACK = 1; LOCAL_RDATA = 32'h2A;
      @(negedge CLK);
      LOCAL_ACK = 0; LOCAL_RDATA = 32'hDEADBEEF;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if ({LOCAL_CS, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP} !== {1'b0, 1'b1, 32'h2A, 2'b00}) begin
            n_fail++;
            $display("FAIL rd_resp_%0d: got cs=%b rv=%b rdata=%h rresp=%b required 0 1 2a 00",
                     c, LOCAL_CS, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP);
         end
         if (c == 1) S_AXI_RREADY = 1;
         @(negedge CLK);
      end
      S_AXI_RREADY = 0;
      n_checks++;
      if ({S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY} !== 3'b010) begin
         n_fail++;
         $display("FAIL rd_done: got rv/awr/arr=%b%b%b required 010", S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY);
      end
   endtask

   // read of 0x2000 that is never acknowledged
   task automatic test_read_timeout();
      int cs_cnt;
      S_AXI_ARADDR = 32'h2000; S_AXI_ARVALID = 1;
      for (int i = 0; i < 10 && LOCAL_CS !== 1'b1; i++) @(negedge CLK);
      S_AXI_ARVALID = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR} !== {1'b1, 1'b1, 32'h2000}) begin
         n_fail++;
         $display("FAIL to_start: got cs=%b rnw=%b addr=%h required 1 1 2000", LOCAL_CS, LOCAL_RNW, LOCAL_ADDR);
      end
      cs_cnt = 0;
      while (LOCAL_CS === 1'b1 && cs_cnt < 400) begin
         cs_cnt++;
         @(negedge CLK);
      end
      n_checks++;
      if (cs_cnt != 256) begin
         n_fail++;
         $display("FAIL to_cs_len: got %0d cycles required 256", cs_cnt);
      end
      n_checks++;
      if ({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== {1'b1, 2'b10, 32'h0}) begin
         n_fail++;
         $display("FAIL to_resp: got rv=%b rresp=%b rdata=%h required 1 10 0", S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA);
      end
      S_AXI_RREADY = 1;
      @(negedge CLK);
      S_AXI_RREADY = 0;
   endtask

   // ACK arrives in the very cycle the timeout would fire: OKAY wins
   task automatic test_ack_at_timeout();
      int cs_cnt;
      S_AXI_AWADDR = 32'h44; S_AXI_AWVALID = 1;
      S_AXI_WDATA = 32'h5A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      for (int i = 0; i < 10 && LOCAL_CS !== 1'b1; i++) @(negedge CLK);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      cs_cnt = 1;
      while (cs_cnt < 256 && LOCAL_CS === 1'b1) begin
         @(negedge CLK);
         cs_cnt++;
      end
      n_checks++;
      if (LOCAL_CS !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_cs: got cs=%b bv=%b at cycle %0d required cs=1 bv=0", LOCAL_CS, S_AXI_BVALID, cs_cnt);
      end
      LOCAL_ACK = 1;
      @(negedge CLK);
      LOCAL_ACK = 0;
      n_checks++;
      if ({LOCAL_CS, S_AXI_BVALID, S_AXI_BRESP} !== {1'b0, 1'b1, 2'b00}) begin
         n_fail++;
         $display("FAIL tie_resp: got cs=%b bv=%b bresp=%b required 0 1 00", LOCAL_CS, S_AXI_BVALID, S_AXI_BRESP);
      end
      S_AXI_BREADY = 1;
      @(negedge CLK);
      S_AXI_BREADY = 0;
   endtask

   // AW first, W three cycles later; a stray ACK with CS low in between
   task automatic test_w_late();
      S_AXI_AWADDR = 32'h40; S_AXI_AWVALID = 1;
      for (int i = 0; i < 10 && S_AXI_AWREADY !== 1'b1; i++) @(negedge CLK);
      @(negedge CLK);
      S_AXI_AWVALID = 0;
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, LOCAL_CS} !== 4'b0100) begin
         n_fail++;
         $display("FAIL wl_aw_only: got awr/wr/arr/cs=%b%b%b%b required 0100",
                  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, LOCAL_CS);
      end
      LOCAL_ACK = 1;
      @(negedge CLK);
      LOCAL_ACK = 0;
      n_checks++;
      if ({LOCAL_CS, S_AXI_BVALID, S_AXI_RVALID} !== 3'b000) begin
         n_fail++;
         $display("FAIL stray_ack: got cs/bv/rv=%b%b%b required 000", LOCAL_CS, S_AXI_BVALID, S_AXI_RVALID);
      end
      @(negedge CLK);
      S_AXI_WDATA = 32'hCAFE; S_AXI_WSTRB = 4'h3; S_AXI_WVALID = 1;
      @(negedge CLK);
      S_AXI_WVALID = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_WDATA, LOCAL_BE} !== {1'b1, 1'b0, 32'h40, 32'hCAFE, 4'h3}) begin
         n_fail++;
         $display("FAIL wl_local: got cs=%b rnw=%b addr=%h wd=%h be=%h required 1 0 40 cafe 3",
                  LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_WDATA, LOCAL_BE);
      end
      LOCAL_ACK = 1;
      @(negedge CLK);
      LOCAL_ACK = 0;
      n_checks++;
      if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin
         n_fail++;
         $display("FAIL wl_resp: got bv=%b bresp=%b required 1 00", S_AXI_BVALID, S_AXI_BRESP);
      end
      S_AXI_BREADY = 1;
      @(negedge CLK);
      S_AXI_BREADY = 0;
   endtask

   // AW/W/AR together after reset; then stalled B and R channels
   task automatic test_priority_stall();
      apply_reset();
      S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1;
      S_AXI_WDATA = 32'h11111111; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      S_AXI_ARADDR = 32'h3000; S_AXI_ARVALID = 1;
      @(negedge CLK);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, S_AXI_ARREADY} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
         n_fail++;
         $display("FAIL prio_write_first: got cs=%b rnw=%b addr=%h arr=%b required 1 0 10 0",
                  LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, S_AXI_ARREADY);
      end
      LOCAL_ACK = 1;
      @(negedge CLK);
      LOCAL_ACK = 0;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY, LOCAL_CS} !== 5'b10000) begin
            n_fail++;
            $display("FAIL b_stall_%0d: got bv=%b bresp=%b arr=%b cs=%b required 1 00 0 0",
                     i, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY, LOCAL_CS);
         end
         @(negedge CLK);
      end
      S_AXI_BREADY = 1;
      @(negedge CLK);
      S_AXI_BREADY = 0;
      n_checks++;
      if ({S_AXI_BVALID, S_AXI_ARREADY} !== 2'b01) begin
         n_fail++;
         $display("FAIL prio_read_next: got bv=%b arr=%b required 0 1", S_AXI_BVALID, S_AXI_ARREADY);
      end
      @(negedge CLK);
      S_AXI_ARVALID = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR} !== {1'b1, 1'b1, 32'h3000}) begin
         n_fail++;
         $display("FAIL prio_read_local: got cs=%b rnw=%b addr=%h required 1 1 3000", LOCAL_CS, LOCAL_RNW, LOCAL_ADDR);
      end
      LOCAL_ACK = 1; LOCAL_RDATA = 32'h55;
      @(negedge CLK);
      LOCAL_ACK = 0; LOCAL_RDATA = 32'h0;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY, S_AXI_AWREADY} !== {1'b1, 32'h55, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL r_stall_%0d: got rv=%b rdata=%h rresp=%b arr=%b awr=%b required 1 55 00 0 0",
                     i, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY, S_AXI_AWREADY);
         end
         @(negedge CLK);
      end
      S_AXI_RREADY = 1;
      @(negedge CLK);
      S_AXI_RREADY = 0;
      n_checks++;
      if (S_AXI_RVALID !== 1'b0) begin
         n_fail++;
         $display("FAIL r_done: got rv=%b required 0", S_AXI_RVALID);
      end
   endtask

   // reset while a read holds CS, then a normal write
   task automatic test_reset_mid();
      logic saw_rvalid;
      S_AXI_ARADDR = 32'h5000; S_AXI_ARVALID = 1;
      for (int i = 0; i < 10 && LOCAL_CS !== 1'b1; i++) @(negedge CLK);
      S_AXI_ARVALID = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR} !== {1'b1, 1'b1, 32'h5000}) begin
         n_fail++;
         $display("FAIL rm_start: got cs=%b rnw=%b addr=%h required 1 1 5000", LOCAL_CS, LOCAL_RNW, LOCAL_ADDR);
      end
      RST_N = 0;
      @(negedge CLK);
      n_checks++;
      if ({LOCAL_CS, LOCAL_ADDR, S_AXI_RVALID} !== '0) begin
         n_fail++;
         $display("FAIL rm_cs_drop: got cs=%b addr=%h rv=%b required 0 0 0", LOCAL_CS, LOCAL_ADDR, S_AXI_RVALID);
      end
      RST_N = 1;
      saw_rvalid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (S_AXI_RVALID !== 1'b0) saw_rvalid = 1;
      end
      n_checks++;
      if (saw_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_no_rvalid: got rvalid seen=%b required 0", saw_rvalid);
      end
      S_AXI_AWADDR = 32'h20; S_AXI_AWVALID = 1;
      S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      @(negedge CLK);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      n_checks++;
      if ({LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_WDATA} !== {1'b1, 1'b0, 32'h20, 32'h77}) begin
         n_fail++;
         $display("FAIL rm_write: got cs=%b rnw=%b addr=%h wd=%h required 1 0 20 77",
                  LOCAL_CS, LOCAL_RNW, LOCAL_ADDR, LOCAL_WDATA);
      end
      LOCAL_ACK = 1;
      @(negedge CLK);
      LOCAL_ACK = 0;
      n_checks++;
      if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID} !== 4'b1000) begin
         n_fail++;
         $display("FAIL rm_bresp: got bv=%b bresp=%b rv=%b required 1 00 0", S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID);
      end
      S_AXI_BREADY = 1;
      @(negedge CLK);
      S_AXI_BREADY = 0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_timeout();
      test_ack_at_timeout();
      test_w_late();
      test_priority_stall();
      test_reset_mid();
      repeat (2) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
